l1_cmd_arbiter: RTL and testbench

Sequences and shares the single command port of the L1 cache between two requesters: the CPU trace stream and the L2 snoop path. It drives the cache's write/processing handshake, so only one command is ever in flight. Snoops have priority, with a starvation guard for the trace stream. A watchdog recovers from cache commands that never complete. The block sits between the trace driver / L2 model and the L1 cache instance.

---
 rtl/l1_cmd_arbiter_if.sv | 45 ++++
 rtl/l1_cmd_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_l1_cmd_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l1_cmd_arbiter_if.sv
// rtl/l1_cmd_arbiter_if.sv - requester, cache and status signals of the L1 command arbiter
interface l1_cmd_arbiter_if #(
    parameter int ADDR_W = 60,
    parameter int CNT_W  = 32
);
    logic              trace_valid;
    logic              trace_ready;
    logic [2:0]        trace_command;
    logic [ADDR_W-1:0] trace_address;
    logic              snoop_valid;
    logic              snoop_ready;
    logic [2:0]        snoop_command;
    logic [ADDR_W-1:0] snoop_address;
    logic              cache_write;
    logic [2:0]        cache_command;
    logic [ADDR_W-1:0] cache_address;
    logic              cache_processing;
    logic              trace_done;
    logic              snoop_done;
    logic              cmd_error;
    logic              timeout;
    logic              busy;
    logic [CNT_W-1:0]  trace_count;
    logic [CNT_W-1:0]  snoop_count;

    modport master (
        output trace_valid, trace_command, trace_address,
        output snoop_valid, snoop_command, snoop_address,
        output cache_processing,
        input  trace_ready, snoop_ready,
        input  cache_write, cache_command, cache_address,
        input  trace_done, snoop_done, cmd_error, timeout, busy,
        input  trace_count, snoop_count
    );

    modport slave (
        input  trace_valid, trace_command, trace_address,
        input  snoop_valid, snoop_command, snoop_address,
        input  cache_processing,
        output trace_ready, snoop_ready,
        output cache_write, cache_command, cache_address,
        output trace_done, snoop_done, cmd_error, timeout, busy,
        output trace_count, snoop_count
    );
endinterface

// File: rtl/l1_cmd_arbiter.sv
// rtl/l1_cmd_arbiter.sv - shares the L1 cache command port between trace and snoop requesters
module l1_cmd_arbiter #(
    parameter int ADDR_W           = 60,
    parameter int CNT_W            = 32,
    parameter int MAX_SNOOP_STREAK = 4,
    parameter int TIMEOUT          = 1024
) (
    input  logic          clk,
    input  logic          rst,
    l1_cmd_arbiter_if.slave bus
);
    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_ISSUE      = 2'd1;
    localparam logic [1:0] ST_WAIT_START = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE  = 2'd3;

    localparam int STRK_W = (MAX_SNOOP_STREAK < 1) ? 1 : $clog2(MAX_SNOOP_STREAK + 1);
    localparam int WD_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [STRK_W-1:0] STRK_MAX = STRK_W'(MAX_SNOOP_STREAK);
    localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic [STRK_W-1:0] streak_q, streak_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic [2:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              own_snoop_q, own_snoop_d;
    logic [CNT_W-1:0]  trace_count_q, trace_count_d;
    logic [CNT_W-1:0]  snoop_count_q, snoop_count_d;
    logic              trace_done_q, trace_done_d;
    logic              snoop_done_q, snoop_done_d;
    logic              cmd_error_q, cmd_error_d;
    logic              timeout_q, timeout_d;

    logic snoop_pick;
    logic trace_pick;
    logic idle_ok;
    logic snoop_fire;
    logic trace_fire;
    logic snoop_legal;
    logic trace_legal;
    logic wd_expire;

    // Arbitration: snoop wins unless it has already starved trace for the full streak
    always_comb begin
        snoop_pick  = bus.snoop_valid && !(bus.trace_valid && (streak_q == STRK_MAX));
        trace_pick  = bus.trace_valid && !snoop_pick;
        idle_ok     = (state_q == ST_IDLE) && !rst;
        snoop_fire  = idle_ok && snoop_pick;
        trace_fire  = idle_ok && trace_pick;
        snoop_legal = (bus.snoop_command == 3'd2) || (bus.snoop_command == 3'd4);
        trace_legal = (bus.trace_command <= 3'd3);
        wd_expire   = (wdog_q == WD_LAST);
    end

    assign bus.snoop_ready   = snoop_fire;
    assign bus.trace_ready   = trace_fire;
    assign bus.cache_write   = (state_q == ST_ISSUE);
    assign bus.cache_command = cmd_q;
    assign bus.cache_address = addr_q;
    assign bus.trace_done    = trace_done_q;
    assign bus.snoop_done    = snoop_done_q;
    assign bus.cmd_error     = cmd_error_q;
    assign bus.timeout       = timeout_q;
    assign bus.busy          = (state_q != ST_IDLE);
    assign bus.trace_count   = trace_count_q;
    assign bus.snoop_count   = snoop_count_q;

    // Next-state logic for the command sequencer, streak guard and watchdog
    always_comb begin
        state_d       = state_q;
        streak_d      = streak_q;
        wdog_d        = wdog_q;
        cmd_d         = cmd_q;
        addr_d        = addr_q;
        own_snoop_d   = own_snoop_q;
        trace_count_d = trace_count_q;
        snoop_count_d = snoop_count_q;
        trace_done_d  = 1'b0;
        snoop_done_d  = 1'b0;
        cmd_error_d   = 1'b0;
        timeout_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (snoop_fire) begin
                    if (snoop_legal) begin
                        cmd_d       = bus.snoop_command;
                        addr_d      = bus.snoop_address;
                        own_snoop_d = 1'b1;
                        state_d     = ST_ISSUE;
                        if (!bus.trace_valid) begin
                            streak_d = '0;
                        end else if (streak_q != STRK_MAX) begin
                            streak_d = streak_q + 1'b1;
                        end
                    end else begin
                        cmd_error_d = 1'b1;
                    end
                end else if (trace_fire) begin
                    if (trace_legal) begin
                        cmd_d       = bus.trace_command;
                        addr_d      = bus.trace_address;
                        own_snoop_d = 1'b0;
                        state_d     = ST_ISSUE;
                        streak_d    = '0;
                    end else begin
                        cmd_error_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                wdog_d  = '0;
                state_d = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                wdog_d = wdog_q + 1'b1;
                // A command that never started is aborted without being counted
                if (wd_expire) begin
                    timeout_d    = 1'b1;
                    trace_done_d = !own_snoop_q;
                    snoop_done_d = own_snoop_q;
                    state_d      = ST_IDLE;
                end else if (bus.cache_processing) begin
                    state_d = ST_WAIT_DONE;
                    if (own_snoop_q) begin
                        snoop_count_d = snoop_count_q + 1'b1;
                    end else begin
                        trace_count_d = trace_count_q + 1'b1;
                    end
                end
            end
            default: begin
                wdog_d = wdog_q + 1'b1;
                // Completion takes precedence over a watchdog expiring on the same cycle
                if (!bus.cache_processing) begin
                    trace_done_d = !own_snoop_q;
                    snoop_done_d = own_snoop_q;
                    state_d      = ST_IDLE;
                end else if (wd_expire) begin
                    timeout_d    = 1'b1;
                    trace_done_d = !own_snoop_q;
                    snoop_done_d = own_snoop_q;
                    state_d      = ST_IDLE;
                end
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight command silently
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            streak_q      <= '0;
            wdog_q        <= '0;
            cmd_q         <= '0;
            addr_q        <= '0;
            own_snoop_q   <= 1'b0;
            trace_count_q <= '0;
            snoop_count_q <= '0;
            trace_done_q  <= 1'b0;
            snoop_done_q  <= 1'b0;
            cmd_error_q   <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            streak_q      <= streak_d;
            wdog_q        <= wdog_d;
            cmd_q         <= cmd_d;
            addr_q        <= addr_d;
            own_snoop_q   <= own_snoop_d;
            trace_count_q <= trace_count_d;
            snoop_count_q <= snoop_count_d;
            trace_done_q  <= trace_done_d;
            snoop_done_q  <= snoop_done_d;
            cmd_error_q   <= cmd_error_d;
            timeout_q     <= timeout_d;
        end
    end
endmodule

// File: tb/tb_l1_cmd_arbiter.sv
// tb/tb_l1_cmd_arbiter.sv - directed scoreboard bench for l1_cmd_arbiter
module tb_l1_cmd_arbiter;
    localparam int ADDR_W = 60;
    localparam int CNT_W  = 32;
    localparam int MAXS   = 4;
    localparam int TMO    = 16;

    typedef struct packed {
        logic [2:0]        cmd;
        logic [ADDR_W-1:0] addr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    l1_cmd_arbiter_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    l1_cmd_arbiter #(
        .ADDR_W(ADDR_W), .CNT_W(CNT_W), .MAX_SNOOP_STREAK(MAXS), .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   hold = 0;
    int   left = 0;
    exp_t sb_q[$];

    bit   got_s, got_t, prev_write;
    int   acc_cyc, write_cyc, tdone_cyc, sdone_cyc, tmo_cyc, cerr_cyc;
    int   n_write, n_tdone, n_sdone, n_tmo, n_cerr, n_sready;
    logic s_busy, s_tready, s_sready, s_write, s_proc;
    logic [CNT_W-1:0] s_tcount, s_scount;
    string exp_order = "SSSSTSSSSTSS";

    // Cache model: processing rises the cycle after the strobe, stays high for 'hold' cycles (-1: forever)
    always @(posedge clk) begin
        if (rst) begin
            bus.cache_processing <= 1'b0;
            left <= 0;
        end else if (bus.cache_write) begin
            bus.cache_processing <= (hold != 0);
            left <= hold;
        end else if (left > 0) begin
            left <= left - 1;
            if (left == 1) bus.cache_processing <= 1'b0;
        end
    end

    function automatic bit t_legal(input logic [2:0] c);
        return c <= 3'd3;
    endfunction

    function automatic bit s_legal(input logic [2:0] c);
        return (c == 3'd2) || (c == 3'd4);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample and score at the falling edge, return just after the next rising edge
    task automatic tick();
        exp_t e;
        @(negedge clk);
        got_s    = bus.snoop_valid && bus.snoop_ready;
        got_t    = bus.trace_valid && bus.trace_ready;
        s_busy   = bus.busy;
        s_tready = bus.trace_ready;
        s_sready = bus.snoop_ready;
        s_write  = bus.cache_write;
        s_proc   = bus.cache_processing;
        s_tcount = bus.trace_count;
        s_scount = bus.snoop_count;
        if (got_s) begin
            acc_cyc = cyc;
            if (s_legal(bus.snoop_command)) sb_q.push_back({bus.snoop_command, bus.snoop_address});
        end
        if (got_t) begin
            acc_cyc = cyc;
            if (t_legal(bus.trace_command)) sb_q.push_back({bus.trace_command, bus.trace_address});
        end
        if (bus.cache_write) begin
            n_write++;
            write_cyc = cyc;
            check("write_single_cycle", prev_write, 0);
            check("sb_has_entry", sb_q.size() > 0, 1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("cache_command", bus.cache_command, e.cmd);
                check("cache_address", bus.cache_address, e.addr);
            end
        end
        prev_write = bus.cache_write;
        if (bus.trace_done) begin n_tdone++; tdone_cyc = cyc; end
        if (bus.snoop_done) begin n_sdone++; sdone_cyc = cyc; end
        if (bus.timeout)    begin n_tmo++;   tmo_cyc   = cyc; end
        if (bus.cmd_error)  begin n_cerr++;  cerr_cyc  = cyc; end
        if (bus.snoop_ready) n_sready++;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.trace_valid = 1'b0;
        bus.snoop_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        sb_q.delete();
        n_write = 0; n_tdone = 0; n_sdone = 0; n_tmo = 0; n_cerr = 0; n_sready = 0;
        tdone_cyc = -1; sdone_cyc = -1; tmo_cyc = -1; cerr_cyc = -1; acc_cyc = -1; write_cyc = -1;
    endtask

    task automatic wait_accept(input string tag);
        for (int i = 0; i < 60; i++) begin
            tick();
            if (got_s || got_t) break;
        end
        check({tag, "_accept"}, got_s || got_t, 1);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 200; i++) begin
            tick();
            if (s_busy === 1'b0) break;
        end
        check({tag, "_idle"}, s_busy, 0);
    endtask

    initial begin
        bus.trace_valid   = 1'b1;
        bus.snoop_valid   = 1'b1;
        bus.trace_command = 3'd0;
        bus.snoop_command = 3'd2;
        bus.trace_address = '0;
        bus.snoop_address = '0;
        prev_write = 1'b0;

        // Reset state: readies forced low even with both requesters valid
        tick();
        check("rst_trace_ready", s_tready, 0);
        check("rst_snoop_ready", s_sready, 0);
        check("rst_busy", s_busy, 0);
        check("rst_write", s_write, 0);
        check("rst_trace_count", s_tcount, 0);
        check("rst_snoop_count", s_scount, 0);

        // Single trace READ
        do_reset();
        hold = 3;
        bus.trace_command = 3'd0;
        bus.trace_address = 60'h123_4567_89AB;
        bus.trace_valid   = 1'b1;
        wait_accept("t1");
        check("t1_grant_trace", got_t, 1);
        bus.trace_valid = 1'b0;
        wait_idle("t1");
        check("t1_writes", n_write, 1);
        check("t1_write_latency", write_cyc - acc_cyc, 1);
        check("t1_trace_done", n_tdone, 1);
        check("t1_done_latency", tdone_cyc - acc_cyc, 6);
        check("t1_snoop_done", n_sdone, 0);
        check("t1_timeout", n_tmo, 0);
        check("t1_trace_count", s_tcount, 1);

        // Both valid for 12 commands: streak guard lets trace in every fifth grant
        do_reset();
        hold = 1;
        bus.trace_command = 3'd0;
        bus.trace_address = 60'h1000;
        bus.snoop_command = 3'd2;
        bus.snoop_address = 60'h2000;
        bus.trace_valid   = 1'b1;
        bus.snoop_valid   = 1'b1;
        for (int k = 0; k < 12; k++) begin
            wait_accept("t2");
            check("t2_grant_order", got_s, exp_order[k] == "S");
            if (got_s) begin
                bus.snoop_command = (bus.snoop_command == 3'd2) ? 3'd4 : 3'd2;
                bus.snoop_address = bus.snoop_address + 1;
            end else begin
                bus.trace_command = (bus.trace_command + 3'd1) & 3'd3;
                bus.trace_address = bus.trace_address + 1;
            end
            if (k == 11) begin
                bus.trace_valid = 1'b0;
                bus.snoop_valid = 1'b0;
            end
        end
        wait_idle("t2");
        check("t2_snoop_count", s_scount, 10);
        check("t2_trace_count", s_tcount, 2);
        check("t2_writes", n_write, 12);
        check("t2_snoop_done", n_sdone, 10);
        check("t2_trace_done", n_tdone, 2);
        check("t2_sb_drained", sb_q.size(), 0);

        // Illegal snoop then illegal trace command: accepted and dropped
        do_reset();
        hold = 3;
        bus.snoop_command = 3'd0;
        bus.snoop_address = 60'h5;
        bus.snoop_valid   = 1'b1;
        wait_accept("t3s");
        check("t3_grant_snoop", got_s, 1);
        bus.snoop_valid = 1'b0;
        tick();
        check("t3_cmd_error_next", cerr_cyc - acc_cyc, 1);
        repeat (3) tick();
        check("t3_cmd_error_count", n_cerr, 1);
        check("t3_snoop_ready_cycles", n_sready, 1);
        check("t3_no_write", n_write, 0);
        check("t3_snoop_count", s_scount, 0);
        check("t3_busy", s_busy, 0);
        bus.trace_command = 3'd5;
        bus.trace_valid   = 1'b1;
        wait_accept("t3t");
        bus.trace_valid = 1'b0;
        repeat (2) tick();
        check("t3_trace_cmd_error", n_cerr, 2);
        check("t3_trace_no_write", n_write, 0);
        check("t3_trace_count", s_tcount, 0);

        // Trace WRITE with processing stuck high: watchdog abort after start
        do_reset();
        hold = -1;
        bus.trace_command = 3'd1;
        bus.trace_address = 60'hABC;
        bus.trace_valid   = 1'b1;
        wait_accept("t4");
        bus.trace_valid = 1'b0;
        wait_idle("t4");
        check("t4_timeout_count", n_tmo, 1);
        check("t4_trace_done", n_tdone, 1);
        check("t4_timeout_latency", tmo_cyc - acc_cyc, 2 + TMO);
        check("t4_done_with_timeout", tdone_cyc - tmo_cyc, 0);
        check("t4_trace_count", s_tcount, 1);

        // Snoop never started: aborted in WAIT_START and not counted
        do_reset();
        hold = 0;
        bus.snoop_command = 3'd2;
        bus.snoop_address = 60'h77;
        bus.snoop_valid   = 1'b1;
        wait_accept("t4b");
        bus.snoop_valid = 1'b0;
        wait_idle("t4b");
        check("t4b_timeout_count", n_tmo, 1);
        check("t4b_snoop_done", n_sdone, 1);
        check("t4b_timeout_latency", sdone_cyc - acc_cyc, 2 + TMO);
        check("t4b_snoop_count", s_scount, 0);

        // Reset while in WAIT_DONE
        do_reset();
        hold = -1;
        bus.trace_command = 3'd1;
        bus.trace_address = 60'h99;
        bus.trace_valid   = 1'b1;
        wait_accept("t5");
        bus.trace_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        bus.trace_valid   = 1'b1;
        bus.snoop_command = 3'd2;
        bus.snoop_valid   = 1'b1;
        tick();
        check("t5_in_wait_done_busy", s_busy, 1);
        check("t5_in_wait_done_count", s_tcount, 1);
        check("t5_rst_trace_ready", s_tready, 0);
        check("t5_rst_snoop_ready", s_sready, 0);
        tick();
        check("t5_busy_after_rst", s_busy, 0);
        check("t5_tcount_after_rst", s_tcount, 0);
        check("t5_rst_trace_ready_idle", s_tready, 0);
        check("t5_rst_snoop_ready_idle", s_sready, 0);
        bus.trace_valid = 1'b0;
        bus.snoop_valid = 1'b0;
        rst = 1'b0;
        repeat (3) tick();
        check("t5_no_trace_done", n_tdone, 0);
        check("t5_no_timeout", n_tmo, 0);

        // Processing falls on the very cycle the watchdog would expire
        do_reset();
        hold = TMO - 1;
        bus.trace_command = 3'd0;
        bus.trace_address = 60'h4242;
        bus.trace_valid   = 1'b1;
        wait_accept("t6");
        bus.trace_valid = 1'b0;
        wait_idle("t6");
        check("t6_trace_done", n_tdone, 1);
        check("t6_no_timeout", n_tmo, 0);
        check("t6_done_latency", tdone_cyc - acc_cyc, 2 + TMO);
        check("t6_trace_count", s_tcount, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
